// File: rtl/strand_receiver_pkg.sv
// strand_receiver_pkg: shared strand link definitions used by both the strand
// receiver and the strand driver. Keeping them in one place stops the two sides
// from drifting apart. It holds the pixel and index widths, the WS2811 bit timings
// and decode thresholds, and the receiver FSM state encoding.
`timescale 1ns/1ps
package strand_receiver_pkg;

  localparam int MEM_DATA_WIDTH     = 24;
  localparam int STRAND_PARAM_WIDTH = 16;
  localparam int GAP_W              = 16;
  localparam int HIGH_W             = 8;
  localparam int BIT_CNT_W          = 5;

  // WS2811 driver timings in 100 MHz clk cycles
  localparam int T0H      = 50;
  localparam int T0L      = 200;
  localparam int T1H      = 120;
  localparam int T1L      = 130;
  localparam int TRESET   = 6000;
  localparam int TCLKDIV2 = 10;

  // Receiver decode thresholds, sized to the counters that compare against them
  localparam logic [HIGH_W-1:0]             BIT_THRESH    = 8'd85;
  localparam logic [HIGH_W-1:0]             MAX_HIGH      = 8'd250;
  localparam logic [GAP_W-1:0]              RESET_GAP     = 16'd5000;
  localparam logic [BIT_CNT_W-1:0]          LAST_BIT      = 5'd23;
  localparam logic [STRAND_PARAM_WIDTH-1:0] PIXEL_IDX_MAX = 16'hFFFF;

  typedef enum logic [1:0] {
    RX_IDLE = 2'd0,
    RX_HIGH = 2'd1,
    RX_LOW  = 2'd2,
    RX_END  = 2'd3
  } rx_state_t;

endpackage

// File: rtl/strand_receiver_if.sv
// strand_receiver_if: pad-side inputs and capture-RAM-side outputs of the strand
// receiver. The master side drives the strand lines and mode. The slave side is
// the receiver itself.
`timescale 1ns/1ps
interface strand_receiver_if;
  import strand_receiver_pkg::*;

  logic                          ws2811_mode;
  logic                          strand_clk_in;
  logic                          strand_data_in;
  logic [MEM_DATA_WIDTH-1:0]     pixel_data;
  logic [STRAND_PARAM_WIDTH-1:0] pixel_idx;
  logic                          pixel_valid;
  logic                          frame_done;
  logic [STRAND_PARAM_WIDTH-1:0] frame_length;
  logic                          busy;
  logic                          error;

  modport master (
    output ws2811_mode, strand_clk_in, strand_data_in,
    input  pixel_data, pixel_idx, pixel_valid, frame_done, frame_length, busy, error
  );

  modport slave (
    input  ws2811_mode, strand_clk_in, strand_data_in,
    output pixel_data, pixel_idx, pixel_valid, frame_done, frame_length, busy, error
  );

endinterface

// File: rtl/strand_receiver_rx_sync.sv
// strand_rx_sync: brings one asynchronous strand pad line into the clk domain.
// It uses a 2-FF synchronizer, an optional 3-sample majority glitch filter, and a
// rising-edge strobe.
// The glitch filter is built when STRAND_RX_GLITCH_FILTER_EN is defined. It adds
// 2 cycles of latency to both edges, so pulse widths are preserved.
`timescale 1ns/1ps
module strand_rx_sync (
  input  logic clk,
  input  logic rst_n,
  input  logic i_async,
  output logic o_level,
  output logic o_rise
);

  logic r_meta;
  logic r_sync;
  logic r_prev;
  logic w_level;

  // Two-flop synchronizer for the asynchronous pad input
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_meta <= 1'b0;
      r_sync <= 1'b0;
    end else begin
      r_meta <= i_async;
      r_sync <= r_meta;
    end
  end

`ifdef STRAND_RX_GLITCH_FILTER_EN
  logic [1:0] r_hist;
  logic       r_filt;

  // Majority of the last three synchronized samples rejects single-cycle pulses
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_hist <= 2'b00;
      r_filt <= 1'b0;
    end else begin
      r_hist <= {r_hist[0], r_sync};
      r_filt <= (r_sync & r_hist[0]) | (r_sync & r_hist[1]) | (r_hist[0] & r_hist[1]);
    end
  end

  assign w_level = r_filt;
`else
  assign w_level = r_sync;
`endif

  // Previous level, kept for rising-edge detection
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_prev <= 1'b0;
    end else begin
      r_prev <= w_level;
    end
  end

  assign o_level = w_level;
  assign o_rise  = w_level & ~r_prev;

endmodule

// File: rtl/strand_receiver.sv
// strand_receiver: decodes a WS2811 one-wire or WS2801 clock/data strand stream
// back into 24-bit pixel words. Bits arrive LSB first. It reports pixel index,
// frame boundaries, frame length and a sticky error.
// The optional pad glitch filter is selected with STRAND_RX_GLITCH_FILTER_EN.
`timescale 1ns/1ps
module strand_receiver
  import strand_receiver_pkg::*;
(
  input logic              clk,
  input logic              rst_n,
  strand_receiver_if.slave bus
);

  logic w_dataLevel;
  logic w_dataRise;
  logic w_clkLevel;
  logic w_clkRise;
  logic w_startEdge;
  logic w_lineLevel;
  logic w_lineRise;
  logic w_bitStrobe;
  logic w_bitValue;
  logic [BIT_CNT_W-1:0] w_bitIdx;

  rx_state_t                     r_state;
  logic                          r_mode;
  logic [HIGH_W-1:0]             r_highCnt;
  logic [GAP_W-1:0]              r_gapCnt;
  logic [BIT_CNT_W-1:0]          r_bitCnt;
  logic [MEM_DATA_WIDTH-1:0]     r_word;
  logic                          r_wordDone;
  logic [MEM_DATA_WIDTH-1:0]     r_pixelData;
  logic [STRAND_PARAM_WIDTH-1:0] r_pixelIdx;
  logic                          r_pixelValid;
  logic                          r_frameDone;
  logic [STRAND_PARAM_WIDTH-1:0] r_frameLength;
  logic                          r_busy;
  logic                          r_error;

  strand_rx_sync u_dataSync (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_async (bus.strand_data_in),
    .o_level (w_dataLevel),
    .o_rise  (w_dataRise)
  );

  strand_rx_sync u_clkSync (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_async (bus.strand_clk_in),
    .o_level (w_clkLevel),
    .o_rise  (w_clkRise)
  );

  // Frame start follows the live mode pin. Once in a frame, the latched mode picks
  // which line is watched for gaps.
  assign w_startEdge = bus.ws2811_mode ? w_dataRise : w_clkRise;
  assign w_lineLevel = r_mode ? w_dataLevel : w_clkLevel;
  assign w_lineRise  = r_mode ? w_dataRise  : w_clkRise;

  // Decide whether a bit completes this cycle, and its value and word position.
  // In RX_HIGH the data line is known to be high, so a low level is the falling edge.
  always_comb begin
    w_bitStrobe = 1'b0;
    w_bitValue  = w_dataLevel;
    w_bitIdx    = r_bitCnt;
    case (r_state)
      RX_IDLE: begin
        w_bitStrobe = w_startEdge & ~bus.ws2811_mode;
        w_bitIdx    = '0;
      end
      RX_HIGH: begin
        w_bitStrobe = ~w_dataLevel;
        w_bitValue  = (r_highCnt >= BIT_THRESH);
      end
      RX_LOW: begin
        w_bitStrobe = ~r_mode & w_clkRise;
      end
      default: begin
        w_bitStrobe = 1'b0;
      end
    endcase
  end

  // Receive FSM with bit assembly, pixel write strobe and frame bookkeeping
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state       <= RX_IDLE;
      r_mode        <= 1'b0;
      r_highCnt     <= '0;
      r_gapCnt      <= '0;
      r_bitCnt      <= '0;
      r_word        <= '0;
      r_wordDone    <= 1'b0;
      r_pixelData   <= '0;
      r_pixelIdx    <= '0;
      r_pixelValid  <= 1'b0;
      r_frameDone   <= 1'b0;
      r_frameLength <= '0;
      r_busy        <= 1'b0;
      r_error       <= 1'b0;
    end else begin
      r_pixelValid <= 1'b0;
      r_frameDone  <= 1'b0;
      r_wordDone   <= 1'b0;

      case (r_state)
        RX_IDLE: begin
          if (w_startEdge) begin
            r_busy     <= 1'b1;
            r_error    <= 1'b0;
            r_pixelIdx <= '0;
            r_bitCnt   <= '0;
            r_mode     <= bus.ws2811_mode;
            r_gapCnt   <= '0;
            r_highCnt  <= 8'd1;
            r_state    <= bus.ws2811_mode ? RX_HIGH : RX_LOW;
          end
        end
        RX_HIGH: begin
          if (!w_dataLevel) begin
            r_gapCnt <= '0;
            r_state  <= RX_LOW;
          end else if (r_highCnt != MAX_HIGH) begin
            r_highCnt <= r_highCnt + 8'd1;
            if (r_highCnt + 8'd1 == MAX_HIGH) begin
              r_error <= 1'b1;
            end
          end
        end
        RX_LOW: begin
          if (w_lineRise) begin
            r_gapCnt <= '0;
            if (r_mode) begin
              r_highCnt <= 8'd1;
              r_state   <= RX_HIGH;
            end
          end else if (r_gapCnt == RESET_GAP - 16'd1) begin
            r_state <= RX_END;
          end else if (!w_lineLevel) begin
            r_gapCnt <= r_gapCnt + 16'd1;
          end
        end
        RX_END: begin
          r_frameDone   <= 1'b1;
          r_frameLength <= r_pixelIdx;
          r_busy        <= 1'b0;
          if (r_bitCnt != '0) begin
            r_error <= 1'b1;
          end
          r_state <= RX_IDLE;
        end
        default: begin
          r_state <= RX_IDLE;
        end
      endcase

      if (w_bitStrobe) begin
        r_word[w_bitIdx] <= w_bitValue;
        if (w_bitIdx == LAST_BIT) begin
          r_bitCnt   <= '0;
          r_wordDone <= 1'b1;
        end else begin
          r_bitCnt <= w_bitIdx + 5'd1;
        end
      end

      if (r_wordDone) begin
        if (r_pixelIdx == PIXEL_IDX_MAX) begin
          r_error <= 1'b1;
        end else begin
          r_pixelValid <= 1'b1;
          r_pixelData  <= r_word;
        end
      end

      if (r_pixelValid) begin
        r_pixelIdx <= r_pixelIdx + 16'd1;
      end
    end
  end

  assign bus.pixel_data   = r_pixelData;
  assign bus.pixel_idx    = r_pixelIdx;
  assign bus.pixel_valid  = r_pixelValid;
  assign bus.frame_done   = r_frameDone;
  assign bus.frame_length = r_frameLength;
  assign bus.busy         = r_busy;
  assign bus.error        = r_error;

endmodule

// File: tb/tb_strand_receiver.sv
// tb_strand_receiver: self-checking bench for strand_receiver. It uses table-driven
// frames, randomized frames scored against a frame-level model, and hand-written
// sequences for overlong highs, mid-frame reset and single-cycle glitches.
`timescale 1ns/1ps
module tb_strand_receiver;
  import strand_receiver_pkg::*;

  typedef struct {
    logic             mode;
    int               nPix;
    logic [2:0][23:0] words;
    int               extraBits;
    logic             driverTiming;
    int               half;
    int               expLen;
    logic             expErr;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  int          errCount = 0;
  int          checkCount = 0;
  int          doneCount = 0;
  int          startDone = 0;
  logic        gotDone = 1'b0;
  logic [15:0] lastLen = '0;
  logic        lastErr = 1'b0;
  logic [23:0] gotData [$];
  logic [15:0] gotIdx [$];

  strand_receiver_if busIf ();

  strand_receiver u_dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (busIf)
  );

  always #5 clk = ~clk;

  // Capture every pixel write and frame end seen on the output side
  always @(negedge clk) begin
    if (busIf.pixel_valid === 1'b1) begin
      gotData.push_back(busIf.pixel_data);
      gotIdx.push_back(busIf.pixel_idx);
    end
    if (busIf.frame_done === 1'b1) begin
      doneCount++;
      lastLen = busIf.frame_length;
      lastErr = busIf.error;
    end
  end

  // Hard stop in case a wait escapes its own bound
  initial begin
    #3000000;
    $display("[TB] FAIL watchdog: actual=still running required=finished");
    $fatal(1);
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic expectEq(input string name, input longint actual, input longint expected);
    checkCount++;
    if (actual !== expected) begin
      errCount++;
      $display("[TB] FAIL %s: actual=0x%0h required=0x%0h", name, actual, expected);
    end
  endtask

  task automatic sendBit(input logic mode, input logic b, input logic driverTiming, input int half);
    int hi;
    int lo;
    if (mode) begin
      if (driverTiming) begin
        hi = b ? T1H : T0H;
        lo = b ? T1L : T0L;
      end else begin
        hi = b ? int'($urandom_range(150, 90)) : int'($urandom_range(60, 20));
        lo = int'($urandom_range(40, 10));
      end
      busIf.strand_data_in = 1'b1;
      tick(hi);
      busIf.strand_data_in = 1'b0;
      tick(lo);
    end else begin
      busIf.strand_data_in = b;
      tick(half);
      busIf.strand_clk_in = 1'b1;
      tick(half);
      busIf.strand_clk_in = 1'b0;
    end
  endtask

  task automatic beginFrame(input logic mode);
    gotData.delete();
    gotIdx.delete();
    startDone = doneCount;
    busIf.ws2811_mode = mode;
  endtask

  task automatic waitFrameDone();
    int cycles = 0;
    busIf.strand_data_in = 1'b0;
    busIf.strand_clk_in  = 1'b0;
    while (doneCount == startDone && cycles < 5600) begin
      tick(1);
      cycles++;
    end
    tick(1);
    gotDone = (doneCount != startDone);
  endtask

  task automatic applyStimulus(input vec_t v);
    beginFrame(v.mode);
    for (int p = 0; p < v.nPix; p++) begin
      for (int i = 0; i < 24; i++) begin
        sendBit(v.mode, v.words[p][i], v.driverTiming, v.half);
      end
    end
    for (int i = 0; i < v.extraBits; i++) begin
      sendBit(v.mode, i[0], v.driverTiming, v.half);
    end
    waitFrameDone();
  endtask

  task automatic checkOutput(input vec_t v);
    expectEq("frameDone", gotDone, 1);
    expectEq("pixelCount", gotData.size(), v.expLen);
    for (int p = 0; p < gotData.size() && p < v.expLen; p++) begin
      expectEq("pixelData", gotData[p], v.words[p]);
      expectEq("pixelIdx", gotIdx[p], p);
    end
    expectEq("frameLength", lastLen, v.expLen);
    expectEq("frameError", lastErr, v.expErr);
    expectEq("busyAfterFrame", busIf.busy, 0);
  endtask

  function automatic vec_t makeVec(input logic mode, input int nPix,
                                   input logic [23:0] w0, input logic [23:0] w1, input logic [23:0] w2,
                                   input int extraBits, input logic driverTiming, input int half,
                                   input int expLen, input logic expErr);
    vec_t v;
    v.mode = mode;
    v.nPix = nPix;
    v.words[0] = w0;
    v.words[1] = w1;
    v.words[2] = w2;
    v.extraBits = extraBits;
    v.driverTiming = driverTiming;
    v.half = half;
    v.expLen = expLen;
    v.expErr = expErr;
    return v;
  endfunction

  // Reference model: each whole group of 24 bits is one pixel, any leftover bits flag an error
  function automatic vec_t modelFrame(input vec_t v);
    vec_t r = v;
    int totalBits = v.nPix * 24 + v.extraBits;
    r.expLen = totalBits / 24;
    r.expErr = (totalBits % 24) != 0;
    return r;
  endfunction

  task automatic checkAllZero(input string tag);
    expectEq({tag, ".pixelData"}, busIf.pixel_data, 0);
    expectEq({tag, ".pixelIdx"}, busIf.pixel_idx, 0);
    expectEq({tag, ".pixelValid"}, busIf.pixel_valid, 0);
    expectEq({tag, ".frameDone"}, busIf.frame_done, 0);
    expectEq({tag, ".frameLength"}, busIf.frame_length, 0);
    expectEq({tag, ".busy"}, busIf.busy, 0);
    expectEq({tag, ".error"}, busIf.error, 0);
  endtask

  initial begin
    vec_t vecTable [4];
    vec_t v;
    logic [23:0] w;
    int expLen;
    logic expErr;

    vecTable[0] = makeVec(1'b1, 2, 24'hA5F00F, 24'h000001, 24'h0, 0, 1'b1, 0, 2, 1'b0);
    vecTable[1] = makeVec(1'b0, 1, 24'h123456, 24'h0, 24'h0, 0, 1'b0, TCLKDIV2, 1, 1'b0);
    vecTable[2] = makeVec(1'b0, 0, 24'h0, 24'h0, 24'h0, 10, 1'b0, 5, 0, 1'b1);
    vecTable[3] = makeVec(1'b0, 3, 24'hFFFFFF, 24'h000000, 24'h800001, 0, 1'b0, 3, 3, 1'b0);

    busIf.ws2811_mode    = 1'b1;
    busIf.strand_clk_in  = 1'b0;
    busIf.strand_data_in = 1'b0;
    rst_n = 1'b0;
    tick(4);
    checkAllZero("reset");
    rst_n = 1'b1;
    tick(2);

    for (int t = 0; t < 4; t++) begin
      applyStimulus(vecTable[t]);
      checkOutput(vecTable[t]);
    end

    for (int r = 0; r < 3; r++) begin
      v.mode = 1'($urandom_range(1, 0));
      v.nPix = v.mode ? int'($urandom_range(1, 0)) : int'($urandom_range(3, 0));
      v.extraBits = ($urandom_range(2, 0) == 0) ? int'($urandom_range(23, 1)) : 0;
      if (v.nPix == 0 && v.extraBits == 0) v.extraBits = 7;
      v.words[0] = 24'($urandom());
      v.words[1] = 24'($urandom());
      v.words[2] = 24'($urandom());
      v.driverTiming = 1'b0;
      v.half = int'($urandom_range(8, 2));
      v = modelFrame(v);
      applyStimulus(v);
      checkOutput(v);
    end

    // Overlong WS2811 high inside a word raises the error once the ceiling is reached
    beginFrame(1'b1);
    for (int i = 0; i < 3; i++) sendBit(1'b1, 1'b1, 1'b0, 0);
    busIf.strand_data_in = 1'b1;
    tick(200);
    expectEq("errorBeforeCeiling", busIf.error, 0);
    tick(100);
    expectEq("errorAtCeiling", busIf.error, 1);
    busIf.strand_data_in = 1'b0;
    tick(20);
    waitFrameDone();
    expectEq("overlongFrameDone", gotDone, 1);
    expectEq("overlongFrameLength", lastLen, 0);
    expectEq("overlongFrameError", lastErr, 1);

    // The next frame start clears the sticky error
    beginFrame(1'b0);
    w = 24'h3C3C3D;
    sendBit(1'b0, w[0], 1'b0, 5);
    expectEq("errorClearedAtStart", busIf.error, 0);
    expectEq("busyAtStart", busIf.busy, 1);
    for (int i = 1; i < 24; i++) sendBit(1'b0, w[i], 1'b0, 5);
    waitFrameDone();
    checkOutput(makeVec(1'b0, 1, w, 24'h0, 24'h0, 0, 1'b0, 5, 1, 1'b0));

    // Reset after bit 12 of pixel 0 discards the frame; a clean frame follows from idx 0
    beginFrame(1'b1);
    for (int i = 0; i <= 12; i++) sendBit(1'b1, 1'b1, 1'b1, 0);
    tick(20);
    rst_n = 1'b0;
    tick(1);
    rst_n = 1'b1;
    checkAllZero("midReset");
    v = makeVec(1'b0, 1, 24'h0F0F0F, 24'h0, 24'h0, 0, 1'b0, 4, 1, 1'b0);
    applyStimulus(v);
    checkOutput(v);
    expectEq("singleDoneAfterReset", doneCount - startDone, 1);

    // Single-cycle data glitch during the low phase after 23 WS2811 bits
    beginFrame(1'b1);
    w = 24'hEDB6DB;
    for (int i = 0; i < 23; i++) sendBit(1'b1, w[i], 1'b0, 0);
    tick(20);
    busIf.strand_data_in = 1'b1;
    tick(1);
    busIf.strand_data_in = 1'b0;
    waitFrameDone();
`ifdef STRAND_RX_GLITCH_FILTER_EN
    expLen = 0;
    expErr = 1'b1;
`else
    expLen = 1;
    expErr = 1'b0;
`endif
    expectEq("glitchFrameDone", gotDone, 1);
    expectEq("glitchPixelCount", gotData.size(), expLen);
    if (gotData.size() > 0 && expLen > 0) begin
      expectEq("glitchPixelData", gotData[0], 24'h6DB6DB);
    end
    expectEq("glitchFrameLength", lastLen, expLen);
    expectEq("glitchFrameError", lastErr, expErr);

    $display("Result: errors=%0d of %0d checks", errCount, checkCount);
    $finish;
  end

endmodule
